// File: rtl/bespoke_pkg.sv
// Types and constants shared by the int8 datapath blocks (packer, adder tree, ...).
// elem_t is the signed element type every int8 consumer agrees on.
package bespoke_pkg;

    localparam int ELEM_W = 8;

    typedef logic signed [ELEM_W-1:0] elem_t;

    typedef enum logic {
        FILL  = 1'b0,
        STALL = 1'b1
    } packer_state_t;

endpackage

// File: rtl/vec_packer.sv
// Streaming scalar-to-vector packer: collects signed int8 elements into an
// Elements-wide, zero-padded lane vector for the downstream adder tree.
module vec_packer
    import bespoke_pkg::*;
#(
    parameter int Elements = 4,
    parameter int CountW   = $clog2(Elements) + 1
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic [ELEM_W-1:0]                in_data,
    input  logic                             in_valid,
    input  logic                             in_last,
    output logic                             in_ready,
    output logic [Elements-1:0][ELEM_W-1:0]  out_data,
    output logic [CountW-1:0]                out_count,
    output logic                             out_valid,
    input  logic                             out_ready
);

    localparam int              IdxW     = $clog2(Elements);
    localparam logic [IdxW-1:0] LAST_IDX = IdxW'(Elements - 1);

    packer_state_t           state_reg, state_next;
    logic [IdxW-1:0]         idx_reg, idx_next;
    elem_t [Elements-1:0]    fill_reg, fill_next;
    elem_t [Elements-1:0]    out_data_reg, out_data_next;
    logic [CountW-1:0]       out_count_reg, out_count_next;
    logic                    out_valid_reg, out_valid_next;

    logic out_free;
    logic accept;
    logic load;

    // Ready depends only on registered state (and reset), never on out_ready.
    assign in_ready  = (state_reg == FILL) && !rst_in;
    assign accept    = in_valid && in_ready;
    assign out_free  = !out_valid_reg || out_ready;

    assign out_data  = out_data_reg;
    assign out_count = out_count_reg;
    assign out_valid = out_valid_reg;

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        fill_next      = fill_reg;
        out_data_next  = out_data_reg;
        out_count_next = out_count_reg;
        out_valid_next = out_valid_reg && !out_ready;
        load           = 1'b0;

        unique case (state_reg)
            FILL: begin
                if (accept) begin
                    fill_next[idx_reg] = elem_t'(in_data);
                    if (idx_reg == LAST_IDX || in_last) begin
                        // idx stays on the closing lane so the count survives a stall
                        if (out_free) begin
                            load = 1'b1;
                        end else begin
                            state_next = STALL;
                        end
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            STALL: begin
                if (out_free) begin
                    load       = 1'b1;
                    state_next = FILL;
                end
            end
            default: state_next = FILL;
        endcase

        // Clearing the buffer on every load is what zero-pads short vectors.
        if (load) begin
            out_data_next  = fill_next;
            out_count_next = CountW'(idx_reg) + CountW'(1);
            out_valid_next = 1'b1;
            fill_next      = '0;
            idx_next       = '0;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg     <= FILL;
            idx_reg       <= '0;
            fill_reg      <= '0;
            out_data_reg  <= '0;
            out_count_reg <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            fill_reg      <= fill_next;
            out_data_reg  <= out_data_next;
            out_count_reg <= out_count_next;
            out_valid_reg <= out_valid_next;
        end
    end

endmodule
